// File: rtl/accu_pkg.sv
// rtl/accu_pkg.sv - shared constants for the windowed accumulator and its result buffer
//
// Purpose: single source for the accumulator window length and data widths so the
//          accumulator and the result FIFO cannot drift apart.
// Contents:
//   ACCU_WINDOW  samples per windowed sum
//   ACCU_IN_W    accumulator input sample width
//   ACCU_OUT_W   accumulator result width (one guard bit over the input)
package accu_pkg;

  localparam int ACCU_WINDOW = 50;
  localparam int ACCU_IN_W   = 37;
  localparam int ACCU_OUT_W  = ACCU_IN_W + 1;

endpackage

// File: rtl/rise_det.sv
// rtl/rise_det.sv - one-bit registered rising-edge detector
//
// Purpose: turns a level strobe into a single-cycle pulse on its first high cycle.
//          The pulse is combinational from `in`, so no latency is added.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset (clears the history bit)
//   in     in   level strobe
//   pulse  out  high in the first cycle `in` is seen high after being low
module rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic pulse
);

  logic in_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in;
    end
  end

  // A strobe already high when reset releases counts as a fresh edge.
  assign pulse = in & ~in_q;

endmodule

// File: rtl/accu_result_fifo.sv
// rtl/accu_result_fifo.sv - result buffer between the windowed accumulator and its consumer
//
// Purpose: captures one accumulator result per rising edge of data_valid into a
//          circular buffer and presents it first-word-fall-through. When the buffer is
//          full, accu_hold freezes the accumulator through its active-low enable.
// Parameters:
//   data_width  result width (accumulator output width)
//   depth       buffer entries, power of two, 2..64
//   addr_width  pointer width, derived from depth
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   wr_data    in   accumulator result
//   wr_valid   in   accumulator data_valid level
//   accu_hold  out  buffer full, drive accumulator en
//   rd_data    out  head entry
//   rd_valid   out  head entry present
//   rd_ready   in   consumer takes head this cycle
//   count      out  occupancy 0..depth
//   overflow   out  sticky: a capture was dropped
//   clr_ovf    in   clears overflow (a same-cycle drop wins)
module accu_result_fifo
  import accu_pkg::*;
#(
  parameter int data_width = ACCU_OUT_W,
  parameter int depth      = 8,
  parameter int addr_width = $clog2(depth)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [data_width-1:0] wr_data,
  input  logic                         wr_valid,
  output logic                         accu_hold,
  output logic signed [data_width-1:0] rd_data,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [addr_width:0]          count,
  output logic                         overflow,
  input  logic                         clr_ovf
);

  localparam logic [addr_width:0] depth_c = (addr_width + 1)'(depth);
  localparam logic [addr_width:0] one_c   = (addr_width + 1)'(1);
  localparam logic [addr_width-1:0] ptr_one_c = addr_width'(1);

  logic signed [data_width-1:0] mem [depth];
  logic [addr_width-1:0]        wr_ptr;
  logic [addr_width-1:0]        rd_ptr;

  logic push;
  logic pop;
  logic full;
  logic push_ok;
  logic drop;

  rise_det u_rise_det (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (wr_valid),
    .pulse (push)
  );

  assign full     = (count == depth_c);
  assign rd_valid = (count != '0);
  assign pop      = rd_valid & rd_ready;
  // A pop in the same cycle frees the slot, so a push at full still fits.
  assign push_ok  = push & (~full | pop);
  assign drop     = push & full & ~pop;

  // Decoded from registered count only; rd_ready has no path to the hold.
  assign accu_hold = full;
  assign rd_data   = mem[rd_ptr];

  // Storage is not reset; rd_data is only meaningful while rd_valid is high.
  // At full with a simultaneous pop, wr_ptr equals rd_ptr: the head is read
  // combinationally this cycle and overwritten at the edge.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // depth is a power of two, so pointer wrap is natural overflow.
      if (push_ok) begin
        wr_ptr <= wr_ptr + ptr_one_c;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_one_c;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + one_c;
        2'b01:   count <= count - one_c;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: doc/accu_result_fifo.md
# accu_result_fifo

Buffers windowed sums produced by the 50-sample accumulator for the downstream consumer. It captures one result per rising edge of the accumulator's `data_valid` strobe and stores results in order in a parameterised circular buffer. A valid/ready interface presents the results in first-word-fall-through order. When the buffer is full, it asserts a hold output that drives the accumulator's active-low `en`, which freezes the accumulator until space frees up.

## Interface

Parameters:
- `data_width`, 38: result width; equals accumulator `input_width`+1.
- `depth`, 8: buffer entries; power of two, 2..64.
- `addr_width`, $clog2(`depth`): pointer width (derived).

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `wr_data` in `data_width`: signed accumulator result (accumulator `dout`).
- `wr_valid` in 1: accumulator `data_valid`; level, may stay high several cycles.
- `accu_hold` out 1: high = accumulator must hold; wire to accumulator `en` (active-low enable).
- `rd_data` out `data_width`: head entry, signed.
- `rd_valid` out 1: head entry present.
- `rd_ready` in 1: consumer accepts head this cycle.
- `count` out `addr_width`+1: occupancy, 0..`depth`.
- `overflow` out 1: sticky; a capture was dropped.
- `clr_ovf` in 1: clears `overflow`.

## Operation

- **Edge capture:** register `wr_valid` into `wr_valid_q`. Push request `push` = `wr_valid & ~wr_valid_q`. A level held high across cycles yields exactly one push.
- **Pop:** `pop` = `rd_valid & rd_ready`. `rd_ready` with an empty buffer is ignored; pointers do not move.
- **Push accepted** when `count < depth` or `pop` is true in the same cycle. The entry is written at `wr_ptr`, and `wr_ptr` increments modulo `depth`.
- **Push with full buffer and no pop:** the data is dropped, `overflow` is set to 1, and the pointers are unchanged.
- **Count update:**
  - +1 on an accepted push only.
  - −1 on a pop only.
  - Unchanged on simultaneous push and pop, including when `count` = `depth` and when `count` = 0.
  - With `count` = 0, `rd_valid` is low, so there is no pop. The push is accepted and `count` becomes 1.
- **Read path:** `rd_data` = `mem[rd_ptr]` (combinational mux from the register array). `rd_valid` = (`count` != 0).
- **Hold:** `accu_hold` = (`count` == `depth`). It is a registered-state decode with no combinational path from `rd_ready`.
- **Overflow clear:** `clr_ovf` clears `overflow`. If a set and a clear land in the same cycle, set wins.
- **Data handling:** stored values are not modified or sign-extended; the width is passed through exactly.

## Timing

- **Reset (`rst_n`=0 at a clock edge):**
  - `wr_ptr`, `rd_ptr`, `count` go to 0.
  - `wr_valid_q` and `overflow` go to 0.
  - Resulting outputs: `rd_valid`=0, `accu_hold`=0, `count`=0, `overflow`=0.
  - Memory contents are not reset. `rd_data` is don't-care while `rd_valid`=0.
- **Reset mid-operation:** all stored entries are discarded. A `wr_valid` that is high on the first cycle after reset, with `wr_valid_q`=0, counts as a rising edge and is captured.
- **Push latency:** push at edge N gives `rd_valid`=1 and valid `rd_data` after edge N, i.e. visible in cycle N+1. The edge detector adds no extra cycle: the push is sampled on the same edge where `wr_valid` is first seen high.
- **Pop:** head advances after the edge where `pop`=1. The next entry is visible the following cycle.
- **Hold:** `accu_hold` rises the cycle after the push that fills the buffer. It falls the cycle after the first pop from full.
- **Wrap-around:** pointers wrap from `depth`−1 to 0 with no bubble.

## Structure

- **Shared package `accu_pkg`:**
  - `ACCU_WINDOW` = 50.
  - `ACCU_IN_W` = 37.
  - `ACCU_OUT_W` = `ACCU_IN_W`+1.
  - These same constants are used by the accumulator and by this block's default `data_width`.
- **Sub-module `rise_det`:** one-bit registered rising-edge detector. Ports: `clk`, `rst_n`, `in`, `pulse`. Reused for other strobe inputs.
- **Top level:** the buffer array, pointers, count, and flags stay in the top module.

## Test plan

- **Single capture:** reset, then `wr_valid` high 1 cycle with `wr_data`=38'sh3FFFFFFFFF (−1) → next cycle `rd_valid`=1, `rd_data`=−1, `count`=1. Then `rd_ready`=1 for 1 cycle → `rd_valid`=0, `count`=0.
- **Level strobe:** `wr_valid` held high 5 cycles with `wr_data`=100 → exactly one entry, `count`=1.
- **Fill, drop, recover:**
  - 8 pulses with values 1..8 → `count`=8, `accu_hold`=1.
  - 9th pulse (value 9) → dropped, `overflow`=1.
  - Drain → reads 1..8 in order.
  - `clr_ovf` → `overflow`=0.
- **Simultaneous push/pop at full:** `count`=8, then a push of 42 with `rd_ready`=1 in the same cycle → `count` stays 8, `overflow` stays 0. After 8 pops, the last value read is 42.
- **Wrap-around:** 20 push/pop pairs of values 0..19 at occupancy 1–3 → output sequence 0..19 in order, no loss.
- **Reset mid-operation:** `count`=5, `rst_n`=0 for 1 cycle → `count`=0, `rd_valid`=0, `accu_hold`=0, `overflow`=0.
